// File: rtl/inta_eoi_master.sv
// CPU-side 8259A interrupt acknowledge / EOI sequencer (8086 two-pulse INTA, OCW2 write-back).
// Define SPECIFIC_EOI_EN to issue a specific EOI for the vector's low level bits instead of EOI_CMD.
module inta_eoi_master #(
    parameter int          PULSE_CYCLES = 2,
    parameter int          GAP_CYCLES   = 2,
    parameter logic [7:0]  EOI_CMD      = 8'h20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       int_req,
    input  logic       int_en,
    input  logic [7:0] data_in,
    input  logic       eoi_req,
    output logic       inta_n,
    output logic       cs_n,
    output logic       wr_n,
    output logic       a0,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic [7:0] vector,
    output logic       vector_valid,
    output logic       busy,
    output logic [2:0] state_dbg
);

    localparam int MAX_CYCLES = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INTA1   = 3'd1,
        GAP     = 3'd2,
        INTA2   = 3'd3,
        HANDLER = 3'd4,
        EOI_WR  = 3'd5,
        RECOVER = 3'd6
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          capture;
    logic [7:0]    eoi_byte;

    logic       inta_n_d, cs_n_d, wr_n_d, data_oe_d, busy_d;
    logic [7:0] data_out_d;

`ifdef SPECIFIC_EOI_EN
    assign eoi_byte = 8'h60 | {5'b0, vector[2:0]};
`else
    assign eoi_byte = EOI_CMD;
`endif

    assign a0        = 1'b0;
    assign state_dbg = state;

    always_comb begin
        state_next = state;
        cnt_next   = cnt + CW'(1);
        capture    = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (int_req && int_en) state_next = INTA1;
            end
            INTA1: if (cnt == PULSE_LAST) begin
                state_next = GAP;
                cnt_next   = '0;
            end
            GAP: if (cnt == GAP_LAST) begin
                state_next = INTA2;
                cnt_next   = '0;
            end
            INTA2: if (cnt == PULSE_LAST) begin
                state_next = HANDLER;
                cnt_next   = '0;
                capture    = 1'b1;
            end
            HANDLER: begin
                cnt_next = '0;
                if (eoi_req) state_next = EOI_WR;
            end
            EOI_WR: if (cnt == PULSE_LAST) begin
                state_next = RECOVER;
                cnt_next   = '0;
            end
            RECOVER: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so the registered pins change on the same edge.
        inta_n_d   = !(state_next == INTA1 || state_next == INTA2);
        cs_n_d     = (state_next != EOI_WR);
        wr_n_d     = (state_next != EOI_WR);
        data_oe_d  = (state_next == EOI_WR || state_next == RECOVER);
        data_out_d = data_oe_d ? eoi_byte : 8'h00;
        busy_d     = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            inta_n       <= 1'b1;
            cs_n         <= 1'b1;
            wr_n         <= 1'b1;
            data_out     <= 8'h00;
            data_oe      <= 1'b0;
            vector       <= 8'h00;
            vector_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            inta_n       <= inta_n_d;
            cs_n         <= cs_n_d;
            wr_n         <= wr_n_d;
            data_out     <= data_out_d;
            data_oe      <= data_oe_d;
            vector_valid <= capture;
            if (capture) vector <= data_in;
            busy         <= busy_d;
        end
    end

endmodule

// File: tb/tb_inta_eoi_master.sv
// Directed self-checking bench for inta_eoi_master at default timing (PULSE_CYCLES=2, GAP_CYCLES=2).
// Build with SPECIFIC_EOI_EN defined to check the specific-EOI byte instead of 8'h20.
module tb_inta_eoi_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       int_req, int_en, eoi_req;
    logic [7:0] data_in;
    logic       inta_n, cs_n, wr_n, a0, data_oe, vector_valid, busy;
    logic [7:0] data_out, vector;
    logic [2:0] state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    inta_eoi_master dut (
        .clk(clk), .rst_n(rst_n), .int_req(int_req), .int_en(int_en),
        .data_in(data_in), .eoi_req(eoi_req), .inta_n(inta_n), .cs_n(cs_n),
        .wr_n(wr_n), .a0(a0), .data_out(data_out), .data_oe(data_oe),
        .vector(vector), .vector_valid(vector_valid), .busy(busy), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [7:0] eoi_byte_for(input logic [7:0] vec);
`ifdef SPECIFIC_EOI_EN
        return 8'h60 | {5'b0, vec[2:0]};
`else
        return 8'h20;
`endif
    endfunction

    // Called at a negedge in IDLE with int_req/int_en already set; ends at the vector_valid cycle.
    task automatic ack_seq(input logic [7:0] vec, input bit drop_int);
        logic pat [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("inta_n_seq", {7'b0, inta_n}, {7'b0, pat[i]});
            check("vv_low_during_inta", {7'b0, vector_valid}, 8'h00);
            check("wr_n_high_during_inta", {7'b0, wr_n}, 8'h01);
            if (i == 0 && drop_int) begin
                int_req = 1'b0;
                int_en  = 1'b0;
            end
            if (i == 3) data_in = vec;
        end
        @(negedge clk);
        check("vector_valid_pulse", {7'b0, vector_valid}, 8'h01);
        check("vector_value", vector, vec);
        check("busy_handler", {7'b0, busy}, 8'h01);
        check("inta_n_after", {7'b0, inta_n}, 8'h01);
    endtask

    // Called at a negedge in HANDLER; ends at the RECOVER cycle.
    task automatic eoi_seq(input logic [7:0] b);
        eoi_req = 1'b1;
        @(negedge clk);
        eoi_req = 1'b0;
        check("vv_one_cycle", {7'b0, vector_valid}, 8'h00);
        for (int i = 0; i < 2; i++) begin
            if (i > 0) @(negedge clk);
            check("eoi_cs_n", {7'b0, cs_n}, 8'h00);
            check("eoi_wr_n", {7'b0, wr_n}, 8'h00);
            check("eoi_a0", {7'b0, a0}, 8'h00);
            check("eoi_data_oe", {7'b0, data_oe}, 8'h01);
            check("eoi_data_out", data_out, b);
            check("eoi_inta_n", {7'b0, inta_n}, 8'h01);
        end
        @(negedge clk);
        check("recover_cs_n", {7'b0, cs_n}, 8'h01);
        check("recover_wr_n", {7'b0, wr_n}, 8'h01);
        check("recover_data_oe", {7'b0, data_oe}, 8'h01);
        check("recover_busy", {7'b0, busy}, 8'h01);
    endtask

    initial begin
        rst_n = 1'b0; int_req = 1'b0; int_en = 1'b0; eoi_req = 1'b0; data_in = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_inta_n", {7'b0, inta_n}, 8'h01);
        check("rst_cs_n", {7'b0, cs_n}, 8'h01);
        check("rst_wr_n", {7'b0, wr_n}, 8'h01);
        check("rst_data_oe", {7'b0, data_oe}, 8'h00);
        check("rst_vector", vector, 8'h00);
        check("rst_vv", {7'b0, vector_valid}, 8'h00);
        check("rst_busy", {7'b0, busy}, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_inta_n", {7'b0, inta_n}, 8'h01);

        // Acknowledge with vector 4B, EOI on the vector_valid cycle, INT kept pending.
        int_req = 1'b1; int_en = 1'b1;
        ack_seq(8'h4B, 1'b0);
        eoi_seq(eoi_byte_for(8'h4B));
        @(negedge clk);
        check("idle_after_recover_busy", {7'b0, busy}, 8'h00);
        check("idle_after_recover_oe", {7'b0, data_oe}, 8'h00);
        check("pending_not_sampled_in_recover", {7'b0, inta_n}, 8'h01);

        // Pending INT starts now; INT is withdrawn mid-sequence and spurious FF is reported.
        ack_seq(8'hFF, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("handler_wait_busy", {7'b0, busy}, 8'h01);
            check("handler_wait_cs_n", {7'b0, cs_n}, 8'h01);
            check("handler_wait_vv", {7'b0, vector_valid}, 8'h00);
        end
        eoi_seq(eoi_byte_for(8'hFF));
        @(negedge clk);
        check("idle2_busy", {7'b0, busy}, 8'h00);

        // eoi_req outside HANDLER must not write.
        eoi_req = 1'b1;
        @(negedge clk);
        eoi_req = 1'b0;
        check("stray_eoi_cs_n", {7'b0, cs_n}, 8'h01);
        check("stray_eoi_busy", {7'b0, busy}, 8'h00);
        @(negedge clk);
        check("stray_eoi_wr_n", {7'b0, wr_n}, 8'h01);

        // INT masked by int_en for 10 cycles, then unmasked.
        int_req = 1'b1; int_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("masked_inta_n", {7'b0, inta_n}, 8'h01);
            check("masked_busy", {7'b0, busy}, 8'h00);
        end
        int_en = 1'b1;
        @(negedge clk);
        check("unmask_inta_n", {7'b0, inta_n}, 8'h00);
        check("unmask_busy", {7'b0, busy}, 8'h01);
        repeat (4) @(negedge clk);
        check("inta2_before_reset", {7'b0, inta_n}, 8'h00);
        data_in = 8'h5A;

        // Async reset in the middle of INTA2.
        #2 rst_n = 1'b0;
        #1;
        check("abort_inta_n", {7'b0, inta_n}, 8'h01);
        check("abort_busy", {7'b0, busy}, 8'h00);
        check("abort_vector", vector, 8'h00);
        int_req = 1'b0; int_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_abort_vv", {7'b0, vector_valid}, 8'h00);
            check("post_abort_cs_n", {7'b0, cs_n}, 8'h01);
            check("post_abort_busy", {7'b0, busy}, 8'h00);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
